// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: state encoding, default map constants
// and the source-page fold used when the trigger register is written.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_DMA_LEN = 160;
  localparam logic [15:0] DMA_REG     = 16'hFF46;

  // Pages E0-FF alias down onto C0-DF (echo RAM), so fold them before use.
  function automatic logic [7:0] src_hi_map(input logic [7:0] d);
    return (d >= 8'hE0) ? (d - 8'h20) : d;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the trigger register copies DMA_LEN bytes from
// page {src_hi,00} into OAM, one read/write pair per byte while the bus is granted.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG,
  parameter logic [15:0] DEST_BASE    = OAM_BASE,
  parameter int          DMA_LEN      = OAM_DMA_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_WE,
  input  logic        bus_grant,
  output logic        bus_req,
  output logic        busy,
  output logic [15:0] address,
  output logic        RE,
  output logic        WE,
  inout  tri   [7:0]  databus
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t r_state, w_state_nx;
  logic [7:0] r_idx, w_idx_nx;
  logic [7:0] r_src_hi, w_src_nx;
  logic [7:0] r_data_q, w_data_nx;

  logic        w_trig;
  logic        w_bus_req, w_re, w_we;
  logic [15:0] w_addr;

  assign w_trig = cpu_WE && (cpu_address == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 8'h00;
      r_src_hi <= 8'h00;
      r_data_q <= 8'h00;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_src_hi <= w_src_nx;
      r_data_q <= w_data_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_src_nx   = r_src_hi;
    w_data_nx  = r_data_q;
    w_bus_req  = 1'b0;
    w_re       = 1'b0;
    w_we       = 1'b0;
    w_addr     = 16'h0000;
    case (r_state)
      IDLE: ;
      REQ: begin
        w_bus_req = 1'b1;
        if (bus_grant) w_state_nx = READ;
      end
      READ: begin
        w_bus_req = 1'b1;
        if (bus_grant) begin
          w_addr     = {r_src_hi, r_idx};
          w_re       = 1'b1;
          w_data_nx  = databus;
          w_state_nx = WRITE;
        end
      end
      WRITE: begin
        w_bus_req = 1'b1;
        if (bus_grant) begin
          w_addr = DEST_BASE + {8'h00, r_idx};
          w_we   = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nx = IDLE;
          end else begin
            w_idx_nx   = r_idx + 8'd1;
            w_state_nx = READ;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
    // A trigger always wins, even over the last write of a running transfer.
    if (w_trig) begin
      w_src_nx   = src_hi_map(cpu_wdata);
      w_idx_nx   = 8'h00;
      w_state_nx = REQ;
    end
  end

  assign bus_req = w_bus_req;
  assign busy    = w_bus_req;
  assign address = w_addr;
  assign RE      = w_re;
  assign WE      = w_we;
  assign databus = w_we ? r_data_q : 8'bz;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: behavioural sram on the shared bus, scripted CPU
// triggers, grant gating, retrigger and mid-transfer reset.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_WE;
  logic        bus_grant;
  logic        bus_req, busy, RE, WE;
  logic [15:0] address;
  tri   [7:0]  databus;

  logic [7:0] src_mem [0:65535];
  logic [7:0] oam     [0:255];
  logic       oam_fill;
  logic [7:0] oam_fill_val;

  logic       gtog;
  logic [2:0] gcnt;
  logic       grant_base;

  int n_tests = 0;
  int n_fail  = 0;

  int busy_cyc = 0, busy_rise = 0, bad_gate = 0, bad_z = 0, req_cyc = 0, both_en = 0;
  logic        busy_d = 1'b0;
  logic [15:0] first_rd, last_rd;
  logic        seen_rd = 1'b0;
  logic        rd_clr = 1'b0;

  oam_dma dut (
    .clk(clk), .rst(rst), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_WE(cpu_WE), .bus_grant(bus_grant), .bus_req(bus_req), .busy(busy),
    .address(address), .RE(RE), .WE(WE), .databus(databus)
  );

  always #5 clk = ~clk;

  assign bus_grant = gtog ? (gcnt < 3'd2) : grant_base;

  // sram read port; while grant is low a foreign master drives a marker value
  assign databus = RE ? ((address[15:8] == 8'hFE) ? oam[address[7:0]] : src_mem[address])
                      : (!bus_grant ? 8'h3C : 8'bz);

  always @(posedge clk) begin
    if (oam_fill) begin
      for (int i = 0; i < 256; i++) oam[i] <= oam_fill_val;
    end else if (WE && address[15:8] == 8'hFE) begin
      oam[address[7:0]] <= databus;
    end
  end

  always @(negedge clk) begin
    gcnt <= (gcnt == 3'd4) ? 3'd0 : gcnt + 3'd1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (busy && !busy_d) busy_rise <= busy_rise + 1;
    busy_d <= busy;
    if (bus_req) req_cyc <= req_cyc + 1;
    if (!bus_grant && (RE || WE)) bad_gate <= bad_gate + 1;
    if (!bus_grant && databus !== 8'h3C) bad_z <= bad_z + 1;
    if (RE && WE) both_en <= both_en + 1;
    if (rd_clr) seen_rd <= 1'b0;
    else if (RE) begin
      if (!seen_rd) first_rd <= address;
      last_rd <= address;
      seen_rd <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_address = a; cpu_wdata = d; cpu_WE = 1'b1;
    @(negedge clk);
    cpu_WE = 1'b0; cpu_address = 16'h0000;
  endtask

  task automatic fill_oam(input logic [7:0] v);
    @(negedge clk);
    oam_fill_val = v; oam_fill = 1'b1;
    @(negedge clk);
    oam_fill = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (busy) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic oam_cmp(input string tag, input logic [7:0] xr, input int lo, input int hi);
    int errs;
    errs = 0;
    for (int i = lo; i <= hi; i++) if (oam[i] !== (8'(i) ^ xr)) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    int b0, r0, g0, z0, q0, errs, n;
    rst = 1'b1; cpu_address = 16'h0; cpu_wdata = 8'h0; cpu_WE = 1'b0;
    grant_base = 1'b0; gtog = 1'b0; oam_fill = 1'b0; oam_fill_val = 8'h00;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'hFF;
    for (int i = 0; i < 160; i++) begin
      src_mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
      src_mem[16'hC100 + i] = 8'(i) ^ 8'hA5;
      src_mem[16'hD000 + i] = 8'(i) ^ 8'h33;
    end
    repeat (3) @(negedge clk);
    // reset state, with grant low so a released databus shows the marker
    chk("rst_bus_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re_we", {RE, WE}, 0);
    chk("rst_addr", address, 0);
    chk("rst_databus", databus, 8'h3C);
    grant_base = 1'b1;
    rst = 1'b0;
    fill_oam(8'h00);

    // plain transfer from C000, grant always high
    b0 = busy_cyc; r0 = busy_rise;
    cpu_write(16'hFF46, 8'hC0);
    wait_idle("t1");
    chk("t1_busy_cycles", busy_cyc - b0, 321);
    chk("t1_busy_rises", busy_rise - r0, 1);
    oam_cmp("t1_oam", 8'h5A, 0, 159);
    chk("t1_fe00", oam[0], 8'h5A);
    chk("t1_fe9f", oam[159], 8'hC5);
    chk("t1_fea0_untouched", oam[160], 8'h00);
    chk("t1_re_we_excl", both_en, 0);

    // grant 2 on / 3 off
    fill_oam(8'h00);
    g0 = bad_gate; z0 = bad_z;
    gtog = 1'b1;
    cpu_write(16'hFF46, 8'hC0);
    @(negedge clk);
    wait_idle("t2");
    gtog = 1'b0;
    oam_cmp("t2_oam", 8'h5A, 0, 159);
    chk("t2_gate_off_rw", bad_gate - g0, 0);
    chk("t2_gate_off_bus", bad_z - z0, 0);

    // echo page E1 folds onto C100
    fill_oam(8'h00);
    rd_clr = 1'b1; @(negedge clk); rd_clr = 1'b0;
    cpu_write(16'hFF46, 8'hE1);
    wait_idle("t3");
    chk("t3_first_rd", first_rd, 16'hC100);
    chk("t3_last_rd", last_rd, 16'hC19F);
    chk("t3_fe00", oam[0], 8'hA5);
    chk("t3_fe9f", oam[159], 8'h3A);

    // retrigger with D0 while reading idx 50
    fill_oam(8'h00);
    b0 = busy_cyc; r0 = busy_rise;
    cpu_write(16'hFF46, 8'hC0);
    n = 0;
    while (!(RE && address == 16'hC032) && n < 1000) begin @(negedge clk); n++; end
    chk("t4_reach_idx50", (RE && address == 16'hC032), 1);
    cpu_address = 16'hFF46; cpu_wdata = 8'hD0; cpu_WE = 1'b1;
    @(negedge clk);
    cpu_WE = 1'b0; cpu_address = 16'h0000;
    wait_idle("t4");
    oam_cmp("t4_oam", 8'h33, 0, 159);
    chk("t4_busy_rises", busy_rise - r0, 1);
    chk("t4_busy_cycles", busy_cyc - b0, 423);

    // reset during WRITE of idx 10
    fill_oam(8'h77);
    cpu_write(16'hFF46, 8'hC0);
    n = 0;
    while (!(WE && address == 16'hFE0A) && n < 1000) begin @(negedge clk); n++; end
    chk("t5_reach_idx10", (WE && address == 16'hFE0A), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {bus_req, busy, RE, WE}, 0);
    chk("t5_rst_addr", address, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b0 = busy_cyc;
    repeat (400) @(negedge clk);
    chk("t5_no_resume", busy_cyc - b0, 0);
    chk("t5_fe09", oam[9], 8'h53);
    errs = 0;
    for (int i = 10; i < 160; i++) if (oam[i] !== 8'h77) errs++;
    chk("t5_tail_untouched", errs, 0);

    // write to a neighbouring address is ignored
    q0 = req_cyc;
    cpu_write(16'hFF47, 8'hC0);
    repeat (5) @(negedge clk);
    chk("t6_no_req", req_cyc - q0, 0);
    chk("t6_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    gcnt = 3'd0;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'hFF46: CPU address of the DMA trigger register.
REQ-002 Parameter DEST_BASE, default 16'hFE00: first OAM destination address.
REQ-003 Parameter DMA_LEN, default 160: bytes per transfer.
REQ-004 Port clk  input  1  system clock; all state updates on posedge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port cpu_address  input  16  CPU bus address.
REQ-007 Port cpu_wdata  input  8  CPU write data.
REQ-008 Port cpu_WE  input  1  CPU write strobe.
REQ-009 Port bus_grant  input  1  arbiter grants the memory bus to DMA.
REQ-010 Port bus_req  output  1  DMA requests the memory bus.
REQ-011 Port busy  output  1  transfer in progress.
REQ-012 Port address  output  16  memory address to the sram.
REQ-013 Port RE  output  1  memory read enable.
REQ-014 Port WE  output  1  memory write enable.
REQ-015 Port databus  inout tri  8  shared memory data bus.

Function
REQ-016 States: IDLE, REQ, READ, WRITE; byte index idx (8-bit); source high byte src_hi; data latch data_q.
REQ-017 Trigger: at a posedge where cpu_WE=1 and cpu_address=DMA_REG_ADDR, load src_hi (cpu_wdata 8'hE0-8'hFF mapped to minus 8'h20), clear idx, go to REQ.
REQ-018 REQ: bus_req=1; on posedge with bus_grant=1 go to READ.
REQ-019 READ with bus_grant=1: address={src_hi,idx}, RE=1; at the posedge, latch databus into data_q and go to WRITE.
REQ-020 WRITE with bus_grant=1: address=DEST_BASE+idx, WE=1, databus driven with data_q; at the posedge, if idx=DMA_LEN-1 go to IDLE, else increment idx and go to READ.
REQ-021 bus_grant=0 in READ/WRITE: RE=WE=0, databus released, state/idx/data_q held; resume in the same state when grant returns.
REQ-022 RE, WE and databus drive are combinational from state and bus_grant; databus is 8'bz whenever not (WRITE and bus_grant).
REQ-023 bus_req=1 and busy=1 in REQ, READ, WRITE; both 0 in IDLE.
REQ-024 address=16'h0000 in IDLE and REQ.
REQ-025 Latency: with bus_grant held high, busy is high for exactly 1+2*DMA_LEN cycles (321 at default).
REQ-026 Retrigger while busy: restart with new src_hi, idx=0, state REQ; in-flight byte abandoned (no write).
REQ-027 Retrigger at the same posedge as the final WRITE: retrigger wins; next state REQ.
REQ-028 CPU writes to other addresses are ignored.

Reset
REQ-029 rst=1 forces immediately state=IDLE, idx=0, src_hi=0, data_q=0; outputs bus_req=busy=RE=WE=0, address=0, databus=z.
REQ-030 Reset mid-transfer aborts without completing the current byte; no resume after release.

Structure
REQ-031 Shared package holds the dma_state_t enum and constants OAM_BASE (16'hFE00), OAM_DMA_LEN (160) and DMA_REG (16'hFF46).
REQ-032 Single module, no sub-modules; a registered state/idx core with a combinational output decode.

Verification
REQ-033 sram preloaded with 8'hC000+i = i^8'h5A; write 8'hC0 to FF46, grant always 1 -> FE00..FE9F = i^8'h5A, busy high 321 cycles.
REQ-034 Grant toggled 3 cycles off every 5 cycles -> identical OAM contents; RE/WE never high while grant=0; databus z while grant=0.
REQ-035 Write 8'hE1 to FF46 -> reads come from 16'hC100..C19F.
REQ-036 Retrigger with 8'hD0 at idx=50 -> FE00..FE9F end with D000..D09F data; a single busy interval, no gap.
REQ-037 rst pulsed in WRITE at idx=10 -> outputs return to reset values in the same cycle; FE0A..FE9F unchanged.
REQ-038 cpu_WE to FF47 with DMA idle -> state stays IDLE, bus_req stays 0.
